aud_rmm_target: RTL and testbench

Target-side responder for the AUD RAM-monitor link: the other end of `aud_rmm`. It deserialises nibble-wide command/address/data frames from the host and performs one single-beat access on a 32-bit internal memory bus. It then drives busy/ready/error status and, for reads, the read data back on the shared 4-bit `aud_data` lines. It sits between the AUD pins (tristate split at the pad) and the on-chip memory interconnect.

---
 rtl/aud_rmm_target.sv | 226 ++++++++++++++++++++++
 tb/tb_aud_rmm_target.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aud_rmm_target.sv
// Target side of the AUD RAM-monitor link: deserialises host frames, performs one
// single-beat access on the internal 32-bit bus and drives the status/read-data response.
module aud_rmm_target #(
    parameter int TURN_CYCLES = 1,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        aud_ck,
    input  logic        rst_n,
    input  logic        aud_nsync,
    input  logic [3:0]  aud_data_i,
    output logic [3:0]  aud_data_o,
    output logic        aud_data_oe,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [1:0]  bus_size,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        bus_err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_WAIT,
        S_TURN,
        S_BUSY,
        S_READY,
        S_RDATA,
        S_ERROR,
        S_DISCARD
    } state_t;

    localparam logic [7:0] TURN_LAST = 8'(TURN_CYCLES - 1);
    localparam logic [7:0] BUSY_LAST = 8'(BUS_TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic [3:0]  cmd;
    logic [31:0] addr_sr;
    logic [31:0] wdata_sr;
    logic [31:0] rdata_sr;
    logic [3:0]  data_nxt;
    logic        oe_nxt;
    logic        we_nxt;
    logic        re_nxt;
    logic        cmd_write;
    logic        cmd_valid;
    logic [7:0]  last_nib;

    // Index of the final nibble for a 2/4/8-nibble transfer of the given size.
    function automatic logic [7:0] nib_last(input logic [1:0] size);
        return (8'd2 << size) - 8'd1;
    endfunction

    assign cmd_write = cmd[2];
    assign cmd_valid = cmd[3] && (cmd[1:0] != 2'b11);
    assign last_nib  = nib_last(cmd[1:0]);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 8'd1;
        case (state)
            S_IDLE: begin
                cnt_nxt = 8'd0;
                if (!aud_nsync) state_nxt = S_CMD;
            end
            S_CMD: begin
                if (aud_nsync) begin
                    state_nxt = S_IDLE;
                end else if (!cmd_valid) begin
                    state_nxt = S_DISCARD;
                end else begin
                    state_nxt = S_ADDR;
                    cnt_nxt   = 8'd1;
                end
            end
            S_ADDR: begin
                if (aud_nsync) begin
                    state_nxt = S_IDLE;
                end else if (cnt == 8'd7) begin
                    state_nxt = cmd_write ? S_WDATA : S_WAIT;
                    cnt_nxt   = 8'd0;
                end
            end
            S_WDATA: begin
                if (aud_nsync) begin
                    state_nxt = S_IDLE;
                end else if (cnt == last_nib) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = 8'd0;
                end
            end
            S_WAIT: begin
                cnt_nxt = 8'd0;
                if (aud_nsync) state_nxt = S_TURN;
            end
            S_TURN: begin
                if (cnt == TURN_LAST) begin
                    state_nxt = S_BUSY;
                    cnt_nxt   = 8'd0;
                end
            end
            S_BUSY: begin
                // Error beats a simultaneous ack; ack on the last allowed cycle still counts.
                if (bus_err) begin
                    state_nxt = S_ERROR;
                    cnt_nxt   = 8'd0;
                end else if (bus_ack) begin
                    state_nxt = S_READY;
                    cnt_nxt   = 8'd0;
                end else if (cnt == BUSY_LAST) begin
                    state_nxt = S_ERROR;
                    cnt_nxt   = 8'd0;
                end
            end
            S_READY: begin
                if (cnt == 8'd1) begin
                    state_nxt = cmd_write ? S_IDLE : S_RDATA;
                    cnt_nxt   = 8'd0;
                end
            end
            S_RDATA: begin
                if (cnt == last_nib) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 8'd0;
                end
            end
            S_ERROR: begin
                if (cnt == 8'd1) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 8'd0;
                end
            end
            S_DISCARD: begin
                cnt_nxt = 8'd0;
                if (aud_nsync) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Pad and request outputs are registered from the next state, so they change
    // on the same edge as the state they belong to.
    always_comb begin
        data_nxt = 4'b0000;
        oe_nxt   = 1'b0;
        we_nxt   = 1'b0;
        re_nxt   = 1'b0;
        case (state_nxt)
            S_BUSY: begin
                oe_nxt = 1'b1;
                we_nxt = cmd_write;
                re_nxt = !cmd_write;
            end
            S_READY: begin
                oe_nxt   = 1'b1;
                data_nxt = 4'b0001;
            end
            S_RDATA: begin
                oe_nxt   = 1'b1;
                data_nxt = rdata_sr[{cnt_nxt[2:0], 2'b00} +: 4];
            end
            S_ERROR: begin
                oe_nxt   = 1'b1;
                data_nxt = 4'b0011;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aud_ck or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= 8'd0;
            aud_data_o  <= 4'b0000;
            aud_data_oe <= 1'b0;
            bus_we      <= 1'b0;
            bus_re      <= 1'b0;
            bus_addr    <= 32'd0;
            bus_wdata   <= 32'd0;
            bus_size    <= 2'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            aud_data_o  <= data_nxt;
            aud_data_oe <= oe_nxt;
            bus_we      <= we_nxt;
            bus_re      <= re_nxt;
            if (state != S_BUSY && state_nxt == S_BUSY) begin
                bus_addr  <= addr_sr;
                bus_wdata <= wdata_sr;
                bus_size  <= cmd[1:0];
            end
        end
    end

    // Frame assembly and read-data capture; these registers need no reset.
    always_ff @(posedge aud_ck) begin
        if (state == S_IDLE && !aud_nsync) begin
            cmd      <= aud_data_i;
            wdata_sr <= 32'd0;
        end
        if (state == S_CMD && !aud_nsync) begin
            addr_sr[3:0] <= aud_data_i;
        end
        if (state == S_ADDR && !aud_nsync) begin
            addr_sr[{cnt[2:0], 2'b00} +: 4] <= aud_data_i;
        end
        if (state == S_WDATA && !aud_nsync) begin
            wdata_sr[{cnt[2:0], 2'b00} +: 4] <= aud_data_i;
        end
        if (state == S_BUSY && bus_ack && !bus_err) begin
            rdata_sr <= bus_rdata;
        end
    end

endmodule

// File: tb/tb_aud_rmm_target.sv
// Scoreboard bench for aud_rmm_target: expected pad nibbles are queued per frame
// and compared against what the target drives once the response appears.
module tb_aud_rmm_target;

    logic        aud_ck = 1'b0;
    logic        rst_n = 1'b0;
    logic        aud_nsync = 1'b1;
    logic [3:0]  aud_data_i = 4'h0;
    logic [3:0]  aud_data_o;
    logic        aud_data_oe;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [1:0]  bus_size;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata = 32'd0;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;

    always #5 aud_ck = ~aud_ck;

    aud_rmm_target #(.TURN_CYCLES(1), .BUS_TIMEOUT(4)) dut (
        .aud_ck(aud_ck),
        .rst_n(rst_n),
        .aud_nsync(aud_nsync),
        .aud_data_i(aud_data_i),
        .aud_data_o(aud_data_o),
        .aud_data_oe(aud_data_oe),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_size(bus_size),
        .bus_we(bus_we),
        .bus_re(bus_re),
        .bus_rdata(bus_rdata),
        .bus_ack(bus_ack),
        .bus_err(bus_err)
    );

    int          cmp_count = 0;
    int          fail_count = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  obs_q[$];
    int          obs_we;
    int          obs_re;
    int          obs_first_oe;
    bit          obs_timed_out;
    bit          obs_stable;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [1:0]  obs_size;

    // Host side: command, address nibbles, data nibbles (nibbles past 8 are 0xF filler).
    task automatic send_frame(input logic [3:0] cmd, input logic [31:0] addr,
                              input logic [31:0] wdata, input int n_addr, input int n_data);
        aud_nsync  = 1'b0;
        aud_data_i = cmd;
        @(posedge aud_ck); #1;
        for (int i = 0; i < n_addr; i++) begin
            aud_data_i = addr[4*i +: 4];
            @(posedge aud_ck); #1;
        end
        for (int i = 0; i < n_data; i++) begin
            aud_data_i = (i < 8) ? wdata[4*i +: 4] : 4'hF;
            @(posedge aud_ck); #1;
        end
        aud_nsync  = 1'b1;
        aud_data_i = 4'h0;
    endtask

    // Memory side plus pad recorder. mode 0: ack, 1: err, 2: ack and err together.
    // ack_delay 0 never responds. Observations land in the obs_* variables.
    task automatic run_response(input int ack_delay, input int mode,
                                input logic [31:0] rdata, input int max_cycles);
        int req;
        bit seen;
        req = 0;
        seen = 1'b0;
        obs_q.delete();
        obs_we = 0;
        obs_re = 0;
        obs_first_oe = -1;
        obs_timed_out = 1'b1;
        obs_stable = 1'b1;
        obs_addr = 32'd0;
        obs_wdata = 32'd0;
        obs_size = 2'd0;
        bus_rdata = rdata;
        for (int c = 0; c < max_cycles; c++) begin
            if (bus_we || bus_re) begin
                if (req == 0) begin
                    obs_addr  = bus_addr;
                    obs_wdata = bus_wdata;
                    obs_size  = bus_size;
                end else if (bus_addr !== obs_addr || bus_wdata !== obs_wdata || bus_size !== obs_size) begin
                    obs_stable = 1'b0;
                end
                req++;
                if (bus_we) obs_we++;
                if (bus_re) obs_re++;
            end
            bus_ack = (bus_we || bus_re) && ack_delay > 0 && req == ack_delay && mode != 1;
            bus_err = (bus_we || bus_re) && ack_delay > 0 && req == ack_delay && mode != 0;
            if (aud_data_oe) begin
                if (!seen) obs_first_oe = c;
                seen = 1'b1;
                obs_q.push_back(aud_data_o);
            end else if (seen) begin
                obs_timed_out = 1'b0;
                break;
            end
            @(posedge aud_ck); #1;
        end
        bus_ack = 1'b0;
        bus_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        cmp_count++;
        if (aud_data_oe !== 1'b0 || aud_data_o !== 4'h0) begin
            fail_count++;
            $display("FAIL reset_pad: oe=%b data=%h want oe=0 data=0", aud_data_oe, aud_data_o);
        end
        cmp_count++;
        if (bus_we !== 1'b0 || bus_re !== 1'b0) begin
            fail_count++;
            $display("FAIL reset_req: we=%b re=%b want 0 0", bus_we, bus_re);
        end
        cmp_count++;
        if (bus_addr !== 32'd0 || bus_wdata !== 32'd0 || bus_size !== 2'd0) begin
            fail_count++;
            $display("FAIL reset_bus: addr=%h wdata=%h size=%0d want 0", bus_addr, bus_wdata, bus_size);
        end
        @(posedge aud_ck); #1;
        rst_n = 1'b1;
        @(posedge aud_ck); #1;
    endtask

    task automatic test_long_write(input logic [31:0] wdata);
        logic [3:0] e;
        logic [3:0] o;
        exp_q = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1};
        send_frame(4'b1110, 32'h01234567, wdata, 8, 8);
        run_response(3, 0, 32'd0, 60);
        cmp_count++;
        if (obs_timed_out !== 1'b0) begin
            fail_count++;
            $display("FAIL lw_end: response never ended (oe never fell), want completion");
        end
        cmp_count++;
        if (obs_we !== 3 || obs_re !== 0) begin
            fail_count++;
            $display("FAIL lw_req_cycles: we=%0d re=%0d want we=3 re=0", obs_we, obs_re);
        end
        cmp_count++;
        if (obs_addr !== 32'h01234567 || obs_wdata !== wdata || obs_size !== 2'd2) begin
            fail_count++;
            $display("FAIL lw_bus: addr=%h wdata=%h size=%0d want 01234567 %h 2", obs_addr, obs_wdata, obs_size, wdata);
        end
        cmp_count++;
        if (obs_stable !== 1'b1) begin
            fail_count++;
            $display("FAIL lw_stable: bus fields changed during request, want stable");
        end
        cmp_count++;
        if (obs_first_oe !== 2) begin
            fail_count++;
            $display("FAIL lw_turn: first oe cycle=%0d want 2", obs_first_oe);
        end
        cmp_count++;
        if (obs_q.size() !== exp_q.size()) begin
            fail_count++;
            $display("FAIL lw_len: nibbles=%0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 4'hx;
            cmp_count++;
            if (o !== e) begin
                fail_count++;
                $display("FAIL lw_nibble: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_reads();
        logic [3:0] e;
        logic [3:0] o;
        // Long read, ack on first BUSY cycle.
        exp_q = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
        send_frame(4'b1010, 32'h01234567, 32'd0, 8, 0);
        run_response(1, 0, 32'h76543210, 60);
        cmp_count++;
        if (obs_re !== 1 || obs_we !== 0 || obs_addr !== 32'h01234567 || obs_size !== 2'd2) begin
            fail_count++;
            $display("FAIL lr_req: re=%0d we=%0d addr=%h size=%0d want 1 0 01234567 2", obs_re, obs_we, obs_addr, obs_size);
        end
        cmp_count++;
        if (obs_q.size() !== exp_q.size() || obs_timed_out !== 1'b0) begin
            fail_count++;
            $display("FAIL lr_len: nibbles=%0d ended=%0d want %0d ended=1", obs_q.size(), !obs_timed_out, exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 4'hx;
            cmp_count++;
            if (o !== e) begin
                fail_count++;
                $display("FAIL lr_nibble: got %h want %h", o, e);
            end
        end
        // Byte read, ack on second BUSY cycle.
        exp_q = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h5, 4'hA};
        send_frame(4'b1000, 32'h00001000, 32'd0, 8, 0);
        run_response(2, 0, 32'h000000A5, 60);
        cmp_count++;
        if (obs_size !== 2'd0 || obs_addr !== 32'h00001000 || obs_re !== 2) begin
            fail_count++;
            $display("FAIL br_req: size=%0d addr=%h re=%0d want 0 00001000 2", obs_size, obs_addr, obs_re);
        end
        cmp_count++;
        if (obs_q.size() !== exp_q.size()) begin
            fail_count++;
            $display("FAIL br_len: nibbles=%0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 4'hx;
            cmp_count++;
            if (o !== e) begin
                fail_count++;
                $display("FAIL br_nibble: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_word_write_extra();
        logic [3:0] e;
        logic [3:0] o;
        // Two surplus nibbles (0xF) after the word data must be ignored; upper bits zero.
        exp_q = '{4'h0, 4'h1, 4'h1};
        send_frame(4'b1101, 32'hDEAD0010, 32'hFFFFBEEF, 8, 6);
        run_response(1, 0, 32'd0, 60);
        cmp_count++;
        if (obs_wdata !== 32'h0000BEEF || obs_size !== 2'd1 || obs_addr !== 32'hDEAD0010 || obs_we !== 1) begin
            fail_count++;
            $display("FAIL ww_bus: wdata=%h size=%0d addr=%h we=%0d want 0000BEEF 1 DEAD0010 1", obs_wdata, obs_size, obs_addr, obs_we);
        end
        cmp_count++;
        if (obs_q.size() !== exp_q.size()) begin
            fail_count++;
            $display("FAIL ww_len: nibbles=%0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 4'hx;
            cmp_count++;
            if (o !== e) begin
                fail_count++;
                $display("FAIL ww_nibble: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_invalid_abort();
        logic [3:0] cmds[2];
        cmds[0] = 4'b0110;
        cmds[1] = 4'b1011;
        for (int k = 0; k < 2; k++) begin
            send_frame(cmds[k], 32'h11112222, 32'd0, 8, 0);
            run_response(1, 0, 32'd0, 20);
            cmp_count++;
            if (obs_q.size() !== 0 || obs_we !== 0 || obs_re !== 0) begin
                fail_count++;
                $display("FAIL invalid_cmd: cmd=%b nibbles=%0d we=%0d re=%0d want 0 0 0", cmds[k], obs_q.size(), obs_we, obs_re);
            end
        end
        send_frame(4'b1010, 32'h33334444, 32'd0, 4, 0);
        run_response(1, 0, 32'd0, 20);
        cmp_count++;
        if (obs_q.size() !== 0 || obs_re !== 0 || obs_we !== 0) begin
            fail_count++;
            $display("FAIL abort: nibbles=%0d re=%0d we=%0d want 0 0 0", obs_q.size(), obs_re, obs_we);
        end
    endtask

    task automatic test_errors();
        logic [3:0] e;
        logic [3:0] o;
        int delays[3];
        int modes[3];
        delays = '{0, 2, 1};
        modes  = '{0, 1, 2};
        for (int k = 0; k < 3; k++) begin
            // Timeout holds the request exactly BUS_TIMEOUT (4) cycles.
            if (k == 0) exp_q = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 4'h3};
            else if (k == 1) exp_q = '{4'h0, 4'h0, 4'h3, 4'h3};
            else exp_q = '{4'h0, 4'h3, 4'h3};
            send_frame(4'b1010, 32'hCAFE0000 + k, 32'd0, 8, 0);
            run_response(delays[k], modes[k], 32'h12345678, 60);
            cmp_count++;
            if (obs_re !== (k == 0 ? 4 : delays[k]) || obs_timed_out !== 1'b0) begin
                fail_count++;
                $display("FAIL err_req: case=%0d re=%0d ended=%0d want re=%0d ended=1", k, obs_re, !obs_timed_out, (k == 0 ? 4 : delays[k]));
            end
            cmp_count++;
            if (obs_q.size() !== exp_q.size()) begin
                fail_count++;
                $display("FAIL err_len: case=%0d nibbles=%0d want %0d", k, obs_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = (obs_q.size() > 0) ? obs_q.pop_front() : 4'hx;
                cmp_count++;
                if (o !== e) begin
                    fail_count++;
                    $display("FAIL err_nibble: case=%0d got %h want %h", k, o, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        int waited;
        send_frame(4'b1110, 32'h0BADF00D, 32'h5A5A5A5A, 8, 8);
        waited = 0;
        while (!bus_we && waited < 10) begin
            @(posedge aud_ck); #1;
            waited++;
        end
        cmp_count++;
        if (bus_we !== 1'b1 || aud_data_oe !== 1'b1) begin
            fail_count++;
            $display("FAIL rst_busy_reach: we=%b oe=%b want 1 1 within 10 cycles", bus_we, aud_data_oe);
        end
        #2;
        rst_n = 1'b0;
        #1;
        cmp_count++;
        if (bus_we !== 1'b0 || bus_re !== 1'b0 || aud_data_oe !== 1'b0) begin
            fail_count++;
            $display("FAIL rst_async: we=%b re=%b oe=%b want 0 0 0", bus_we, bus_re, aud_data_oe);
        end
        @(posedge aud_ck); #1;
        rst_n = 1'b1;
        bus_ack = 1'b1;
        @(posedge aud_ck); #1;
        bus_ack = 1'b0;
        @(posedge aud_ck); #1;
        cmp_count++;
        if (aud_data_oe !== 1'b0 || bus_we !== 1'b0) begin
            fail_count++;
            $display("FAIL rst_late_ack: oe=%b we=%b want 0 0", aud_data_oe, bus_we);
        end
        test_long_write(32'h13579BDF);
    endtask

    initial begin
        test_reset();
        test_long_write(32'h89ABCDEF);
        test_reads();
        test_word_write_extra();
        test_invalid_abort();
        test_reads();
        test_errors();
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
